// File: rtl/store_buffer_pkg.sv
// Shared store-buffer types: op encodings and the queued entry layout.
package store_buffer_pkg;

  localparam int SB_MAX_ADDR_W = 64;

  localparam logic [2:0] SB_OP_WORD   = 3'b000;
  localparam logic [2:0] SB_OP_BYTE_A = 3'b001;
  localparam logic [2:0] SB_OP_BYTE_B = 3'b010;
  localparam logic [2:0] SB_OP_HALF_A = 3'b011;
  localparam logic [2:0] SB_OP_HALF_B = 3'b100;

  // addr holds the word-aligned address zero-extended to SB_MAX_ADDR_W.
  typedef struct packed {
    logic                     valid;
    logic [SB_MAX_ADDR_W-1:0] addr;
    logic [3:0]               byteen;
    logic [31:0]              data;
  } sb_entry_t;

endpackage

// File: rtl/sb_lane_gen.sv
// Combinational store decode: op/addr/data -> byte enables, lane-shifted data, misalignment.
module sb_lane_gen
  import store_buffer_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [3:0]  byteen_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  output logic        op_valid_o
);

  always_comb begin
    byteen_o     = 4'b0000;
    wdata_o      = 32'h0;
    misaligned_o = 1'b0;
    op_valid_o   = 1'b1;
    case (op_i)
      SB_OP_WORD: begin
        byteen_o     = 4'b1111;
        wdata_o      = data_i;
        misaligned_o = (addr_lo_i != 2'b00);
      end
      SB_OP_BYTE_A, SB_OP_BYTE_B: begin
        byteen_o = 4'b0001 << addr_lo_i;
        wdata_o  = {24'h0, data_i[7:0]} << {addr_lo_i, 3'b000};
      end
      SB_OP_HALF_A, SB_OP_HALF_B: begin
        byteen_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = addr_lo_i[1] ? {data_i[15:0], 16'h0} : {16'h0, data_i[15:0]};
        misaligned_o = addr_lo_i[0];
      end
      default: op_valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between MEM and data memory with load-conflict detection.
// Optional STORE_BUFFER_MERGE_EN folds same-word stores into the youngest non-head entry.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [2:0]        st_op,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              st_exc,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_byteen,
  output logic [31:0]       mem_wdata,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_conflict,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sb_entry_t        entries_q [DEPTH];
  sb_entry_t        entries_d [DEPTH];
  sb_entry_t        head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [3:0]        new_byteen;
  logic [31:0]       new_wdata;
  logic              misaligned;
  logic              op_valid;
  logic              full;
  logic              enq_ok;
  logic              merge_hit;
  logic              do_enq;
  logic              do_deq;
  logic [ADDR_W-3:0] st_word;
  logic              unused_ok;

  sb_lane_gen u_lane_gen (
    .op_i        (st_op),
    .addr_lo_i   (st_addr[1:0]),
    .data_i      (st_data),
    .byteen_o    (new_byteen),
    .wdata_o     (new_wdata),
    .misaligned_o(misaligned),
    .op_valid_o  (op_valid)
  );

  assign st_word   = st_addr[ADDR_W-1:2];
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign st_ready  = !full;
  assign st_exc    = st_valid && misaligned;
  assign enq_ok    = st_valid && st_ready && !misaligned && op_valid;
  assign mem_valid = !empty;
  assign do_deq    = mem_valid && mem_ready;
  assign do_enq    = enq_ok && !merge_hit;

`ifdef STORE_BUFFER_MERGE_EN
  logic [PTR_W-1:0] young_ptr;
  assign young_ptr = wr_ptr_q - PTR_W'(1);
  // count >= 2 keeps the head (possibly mid-handshake) out of reach.
  assign merge_hit = enq_ok && (count_q >= CNT_W'(2)) &&
                     (entries_q[young_ptr].addr[ADDR_W-1:2] == st_word);
`else
  assign merge_hit = 1'b0;
`endif

  assign head       = entries_q[rd_ptr_q];
  assign mem_addr   = mem_valid ? head.addr[ADDR_W-1:0] : '0;
  assign mem_byteen = mem_valid ? head.byteen : 4'b0000;
  assign mem_wdata  = mem_valid ? head.data : 32'h0;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entries_d[i] = entries_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_enq) - CNT_W'(do_deq);
    if (do_deq) begin
      entries_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_enq) begin
      entries_d[wr_ptr_q].valid  = 1'b1;
      entries_d[wr_ptr_q].addr   = SB_MAX_ADDR_W'({st_word, 2'b00});
      entries_d[wr_ptr_q].byteen = new_byteen;
      entries_d[wr_ptr_q].data   = new_wdata;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
`ifdef STORE_BUFFER_MERGE_EN
    if (merge_hit) begin
      entries_d[young_ptr].byteen = entries_q[young_ptr].byteen | new_byteen;
      for (int b = 0; b < 4; b++) begin
        if (new_byteen[b]) entries_d[young_ptr].data[8*b +: 8] = new_wdata[8*b +: 8];
      end
    end
`endif
  end

  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries_q[i].valid && (entries_q[i].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]))
        ld_conflict = 1'b1;
    end
  end

  always_comb begin
    unused_ok = ^ld_addr[1:0];
    for (int i = 0; i < DEPTH; i++) unused_ok = unused_ok ^ (^entries_q[i].addr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: vector table plus scoreboarded multi-cycle sequences.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_exc;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic [2:0]  count;
  logic        empty;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exc;
    logic        enq;
    logic [3:0]  be;
    logic [31:0] wd;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[11];

  store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
    .st_addr(st_addr), .st_data(st_data), .st_exc(st_exc),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_byteen(mem_byteen), .mem_wdata(mem_wdata),
    .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drain side: every handshake seen must match the oldest expected store.
  always @(negedge clk) begin
    if (!reset && mem_valid && mem_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual addr=%0h expected=none", mem_addr);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_addr", mem_addr, mon_e.addr);
        chk("sb_byteen", 32'(mem_byteen), 32'(mon_e.be));
        chk("sb_wdata", mem_wdata, mon_e.wd);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be, input logic [31:0] wd, input bit push);
    bit acc = 1'b0;
    st_valid = 1'b1;
    st_op    = op;
    st_addr  = addr;
    st_data  = data;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      if (st_ready) begin
        acc = 1'b1;
        if (push) sb_q.push_back('{addr: addr & 32'hFFFF_FFFC, be: be, wd: wd});
      end
      @(posedge clk);
      #1;
    end
    st_valid = 1'b0;
    chk("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain(input string name);
    mem_ready = 1'b1;
    for (int k = 0; k < 50 && !empty; k++) @(negedge clk);
    @(posedge clk);
    #1;
    chk({name, "_empty"}, 32'(empty), 32'd1);
    chk({name, "_sb_left"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'b001, 32'h0000_1003, 32'h0000_00AB, 1'b0, 1'b1, 4'b1000, 32'hAB00_0000};
    vecs[1]  = '{3'b010, 32'h0000_2000, 32'h1234_56CD, 1'b0, 1'b1, 4'b0001, 32'h0000_00CD};
    vecs[2]  = '{3'b001, 32'h0000_2001, 32'h0000_0077, 1'b0, 1'b1, 4'b0010, 32'h0000_7700};
    vecs[3]  = '{3'b011, 32'h0000_2002, 32'h0000_BEEF, 1'b0, 1'b1, 4'b1100, 32'hBEEF_0000};
    vecs[4]  = '{3'b100, 32'h0000_2000, 32'hFFFF_1234, 1'b0, 1'b1, 4'b0011, 32'h0000_1234};
    vecs[5]  = '{3'b000, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF};
    vecs[6]  = '{3'b011, 32'h0000_1001, 32'h0000_1111, 1'b1, 1'b0, 4'b0000, 32'h0};
    vecs[7]  = '{3'b000, 32'h0000_1002, 32'h2222_2222, 1'b1, 1'b0, 4'b0000, 32'h0};
    vecs[8]  = '{3'b000, 32'h0000_1003, 32'h3333_3333, 1'b1, 1'b0, 4'b0000, 32'h0};
    vecs[9]  = '{3'b101, 32'h0000_4000, 32'h4444_4444, 1'b0, 1'b0, 4'b0000, 32'h0};
    vecs[10] = '{3'b111, 32'h0000_4001, 32'h5555_5555, 1'b0, 1'b0, 4'b0000, 32'h0};

    reset = 1'b1; st_valid = 1'b0; st_op = 3'b0; st_addr = 32'h0; st_data = 32'h0;
    mem_ready = 1'b1; ld_addr = 32'h0;
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_byteen", 32'(mem_byteen), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_ld_conflict", 32'(ld_conflict), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single stores with memory always ready.
    for (int i = 0; i < 11; i++) begin
      st_valid = 1'b1; st_op = vecs[i].op; st_addr = vecs[i].addr; st_data = vecs[i].data;
      @(negedge clk);
      chk("vec_st_exc", 32'(st_exc), 32'(vecs[i].exc));
      chk("vec_count_before", 32'(count), 32'd0);
      if (vecs[i].enq) sb_q.push_back('{addr: vecs[i].addr & 32'hFFFF_FFFC, be: vecs[i].be, wd: vecs[i].wd});
      @(posedge clk);
      #1 st_valid = 1'b0;
      @(negedge clk);
      chk("vec_mem_valid_next", 32'(mem_valid), 32'(vecs[i].enq));
      @(posedge clk);
      @(negedge clk);
      chk("vec_count_after", 32'(count), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("vec_sb_left", 32'(sb_q.size()), 32'd0);

    // Fill to full with memory stalled, then drain while a fifth store waits.
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      send(3'b000, 32'h5000 + 32'(4 * k), 32'hA0A0_0000 + 32'(k), 4'b1111, 32'hA0A0_0000 + 32'(k), 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("full_count", 32'(count), 32'd4);
    chk("full_st_ready", 32'(st_ready), 32'd0);
    chk("full_hold_addr", mem_addr, 32'h5000);
    chk("full_hold_wdata", mem_wdata, 32'hA0A0_0000);
    @(posedge clk);
    #1 mem_ready = 1'b1;
    send(3'b000, 32'h5010, 32'hA0A0_0004, 4'b1111, 32'hA0A0_0004, 1'b1);
    drain("fill");

    // Load conflicts against queued words.
    mem_ready = 1'b0;
    ld_addr = 32'h2000;
    #1 chk("conf_before", 32'(ld_conflict), 32'd0);
    send(3'b000, 32'h2000, 32'h0000_2000, 4'b1111, 32'h0000_2000, 1'b1);
    send(3'b000, 32'h3000, 32'h0000_3000, 4'b1111, 32'h0000_3000, 1'b1);
    ld_addr = 32'h3002;
    #1 chk("conf_3002", 32'(ld_conflict), 32'd1);
    ld_addr = 32'h4000;
    #1 chk("conf_4000", 32'(ld_conflict), 32'd0);
    ld_addr = 32'h2003;
    #1 chk("conf_2003", 32'(ld_conflict), 32'd1);
    drain("conf");
    ld_addr = 32'h3000;
    #1 chk("conf_after_drain", 32'(ld_conflict), 32'd0);

    // Merge sequence: same word stores behind a different-word head.
    mem_ready = 1'b0;
    send(3'b000, 32'h1000, 32'h1122_3344, 4'b1111, 32'h1122_3344, 1'b1);
`ifdef STORE_BUFFER_MERGE_EN
    send(3'b001, 32'h2000, 32'h0000_00AA, 4'b0001, 32'h0000_00AA, 1'b0);
    send(3'b011, 32'h2002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_0000, 1'b0);
    sb_q.push_back('{addr: 32'h2000, be: 4'b1101, wd: 32'hBEEF_00AA});
    @(negedge clk);
    chk("merge_count", 32'(count), 32'd2);
`else
    send(3'b001, 32'h2000, 32'h0000_00AA, 4'b0001, 32'h0000_00AA, 1'b1);
    send(3'b011, 32'h2002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_0000, 1'b1);
    @(negedge clk);
    chk("nomerge_count", 32'(count), 32'd3);
`endif
    @(posedge clk);
    #1;
    drain("merge");

    // Asynchronous reset while the head is stalled.
    mem_ready = 1'b0;
    send(3'b000, 32'h6000, 32'h6666_6666, 4'b1111, 32'h6666_6666, 1'b0);
    @(negedge clk);
    chk("pre_rst_mem_valid", 32'(mem_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    send(3'b001, 32'h7001, 32'h0000_0042, 4'b0010, 32'h0000_4200, 1'b1);
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
